// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and frame constants for the I2C byte path
package i2c_pkg;
    localparam int I2C_BITS = 8;
    localparam int ACK_SLOT = 8;
    typedef enum logic [1:0] {ST_IDLE, ST_BITS, ST_WAIT_FALL, ST_ACK} i2c_state_e;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronise SCL/SDA pads and detect SCL edges and START/STOP
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_STAGES-1:0] scl_q, sda_q;
    logic scl_s, scl_d, sda_d;
    // Shift pads through the synchroniser and keep one cycle of history; reset to idle-high so no false START
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q <= '1;
            sda_q <= '1;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_q <= {scl_q[SYNC_STAGES-2:0], scl_i};
            sda_q <= {sda_q[SYNC_STAGES-2:0], sda_i};
            scl_d <= scl_s;
            sda_d <= sda_s;
        end
    end
    assign scl_s     = scl_q[SYNC_STAGES-1];
    assign sda_s     = sda_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
endmodule

// File: rtl/i2c_recv.sv
// i2c_recv: I2C byte receiver with ACK generation and a one-entry valid/ready holding register
module i2c_recv #(
    parameter bit LSB_FIRST   = 1'b1,
    parameter bit ACK_LEVEL   = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_start,
    output logic       frame_end,
    output logic       busy,
    output logic       overrun
);
    import i2c_pkg::*;
    i2c_state_e state, state_nx;
    logic [2:0] bcnt, bcnt_nx;
    logic [I2C_BITS-1:0] shreg, shreg_nx, shifted;
    logic seen_rise, seen_nx, oe_nx, fs_nx, fe_nx, load, nack, free;
    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_s(sda_s),
        .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det), .stop_det(stop_det)
    );

    assign free    = ~rx_valid | rx_ready;
    assign shifted = LSB_FIRST ? {sda_s, shreg[I2C_BITS-1:1]} : {shreg[I2C_BITS-2:0], sda_s};
    assign busy    = state != ST_IDLE;

    // Next-state logic: bus START/STOP override the frame FSM; ACK decision taken on the fall after bit 8
    always_comb begin
        state_nx = state;
        bcnt_nx  = bcnt;
        shreg_nx = shreg;
        seen_nx  = seen_rise;
        oe_nx    = sda_oe;
        fs_nx    = 1'b0;
        fe_nx    = 1'b0;
        load     = 1'b0;
        nack     = 1'b0;
        if (start_det) begin
            state_nx = ST_BITS;
            bcnt_nx  = '0;
            shreg_nx = '0;
            seen_nx  = 1'b0;
            oe_nx    = 1'b0;
            fs_nx    = 1'b1;
        end else if (stop_det) begin
            if (state != ST_IDLE) begin
                state_nx = ST_IDLE;
                bcnt_nx  = '0;
                shreg_nx = '0;
                seen_nx  = 1'b0;
                oe_nx    = 1'b0;
                fe_nx    = 1'b1;
            end
        end else begin
            case (state)
                ST_BITS: if (scl_rise) begin
                    shreg_nx = shifted;
                    bcnt_nx  = bcnt + 3'd1;
                    if (bcnt == 3'(I2C_BITS-1)) state_nx = ST_WAIT_FALL;
                end
                ST_WAIT_FALL: if (scl_fall) begin
                    load     = free;
                    nack     = ~free;
                    oe_nx    = free ^ ACK_LEVEL;
                    seen_nx  = 1'b0;
                    state_nx = ST_ACK;
                end
                ST_ACK: if (scl_rise) seen_nx = 1'b1;
                    else if (scl_fall && seen_rise) begin
                        oe_nx    = 1'b0;
                        seen_nx  = 1'b0;
                        state_nx = ST_BITS;
                    end
                default: ;
            endcase
        end
    end

    // State, datapath and consumer-side holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bcnt        <= '0;
            shreg       <= '0;
            seen_rise   <= 1'b0;
            sda_oe      <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nx;
            bcnt        <= bcnt_nx;
            shreg       <= shreg_nx;
            seen_rise   <= seen_nx;
            sda_oe      <= oe_nx;
            frame_start <= fs_nx;
            frame_end   <= fe_nx;
            rx_data     <= load ? shreg : rx_data;
            rx_valid    <= load | (rx_valid & ~rx_ready);
            overrun     <= overrun | nack;
        end
    end
endmodule

// File: tb/tb_i2c_recv.sv
// tb_i2c_recv: randomized I2C frames against a transaction-level receiver model, two DUT configurations
module tb_i2c_recv;
    localparam int Q = 4;
    logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda = 1'b1, rx_ready = 1'b0;
    logic sda_bus;
    logic [1:0] oe, rv, fs, fe, bz, ov;
    logic [1:0][7:0] rd;
    int vectors = 0, miscompares = 0;
    int n_start = 0, n_stop = 0;
    int fs_cnt [2];
    int fe_cnt [2];
    logic [7:0] last_rx [2];
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    bit pend = 1'b0, ov_exp = 1'b0;

    always #5 clk = ~clk;
    assign sda_bus = sda & ~oe[0] & ~oe[1];

    i2c_recv #(.LSB_FIRST(1'b1), .ACK_LEVEL(1'b0), .SYNC_STAGES(2)) u0 (
        .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_bus), .sda_oe(oe[0]), .rx_data(rd[0]),
        .rx_valid(rv[0]), .rx_ready(rx_ready), .frame_start(fs[0]), .frame_end(fe[0]),
        .busy(bz[0]), .overrun(ov[0]));
    i2c_recv #(.LSB_FIRST(1'b0), .ACK_LEVEL(1'b1), .SYNC_STAGES(3)) u1 (
        .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_bus), .sda_oe(oe[1]), .rx_data(rd[1]),
        .rx_valid(rv[1]), .rx_ready(rx_ready), .frame_start(fs[1]), .frame_end(fe[1]),
        .busy(bz[1]), .overrun(ov[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev(input logic [7:0] v);
        for (int i = 0; i < 8; i++) rev[i] = v[7-i];
    endfunction

    // Per-cycle compare: any held byte must be the oldest ACKed byte; transfers retire it
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (fs[k]) fs_cnt[k]++;
                if (fe[k]) fe_cnt[k]++;
            end
            if (rv[0]) begin
                if (qa.size() == 0) chk("rx_valid0_no_byte", 32'(rv[0]), 0);
                else begin
                    chk("rx_data0", 32'(rd[0]), 32'(qa[0]));
                    if (rx_ready) begin last_rx[0] = rd[0]; void'(qa.pop_front()); end
                end
            end
            if (rv[1]) begin
                if (qb.size() == 0) chk("rx_valid1_no_byte", 32'(rv[1]), 0);
                else begin
                    chk("rx_data1", 32'(rd[1]), 32'(qb[0]));
                    if (rx_ready) begin last_rx[1] = rd[1]; void'(qb.pop_front()); end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic set_ready(input bit r);
        if (rx_ready) pend = 1'b0;
        rx_ready = r;
    endtask

    task automatic clock_bit(input bit b, input logic [1:0] oe_exp);
        tick(Q); sda = b; tick(Q); scl = 1'b1; tick(Q);
        @(negedge clk);
        chk("sda_oe0", 32'(oe[0]), 32'(oe_exp[0]));
        chk("sda_oe1", 32'(oe[1]), 32'(oe_exp[1]));
        tick(Q); scl = 1'b0;
    endtask

    task automatic bus_start();
        if (!scl) begin tick(Q); sda = 1'b1; tick(Q); scl = 1'b1; tick(2*Q); end
        sda = 1'b0; tick(2*Q); scl = 1'b0; n_start++;
        chk("busy_after_start", 32'(bz), 32'h3);
    endtask

    task automatic bus_stop();
        tick(Q); sda = 1'b0; tick(Q); scl = 1'b1; tick(2*Q); sda = 1'b1; tick(2*Q); n_stop++;
        @(negedge clk);
        chk("busy_after_stop", 32'(bz), 0);
        chk("oe_after_stop", 32'(oe), 0);
        chk("overrun0", 32'(ov[0]), 32'(ov_exp));
        chk("overrun1", 32'(ov[1]), 32'(ov_exp));
        for (int k = 0; k < 2; k++) begin
            chk("frame_start_count", fs_cnt[k], n_start);
            chk("frame_end_count", fe_cnt[k], n_stop);
        end
    endtask

    task automatic data_bits(input logic [7:0] v);
        for (int i = 0; i < 8; i++) clock_bit(v[i], 2'b00);
    endtask

    task automatic decide(input logic [7:0] v, output bit ack);
        ack = !(pend && !rx_ready);
        if (ack) begin qa.push_back(v); qb.push_back(rev(v)); pend = 1'b1; end
        else ov_exp = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit r);
        bit ack;
        set_ready(r);
        data_bits(v);
        decide(v, ack);
        clock_bit(1'b1, {~ack, ack});
    endtask

    task automatic partial(input int n);
        for (int i = 0; i < n; i++) clock_bit(1'($urandom_range(0, 1)), 2'b00);
    endtask

    task automatic drain();
        set_ready(1'b1); tick(6);
        chk("queue0_drained", qa.size(), 0);
        chk("queue1_drained", qb.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit ack;
        for (int k = 0; k < 2; k++) begin fs_cnt[k] = 0; fe_cnt[k] = 0; last_rx[k] = 8'h00; end
        tick(3);
        @(negedge clk);
        chk("reset_outputs", {oe, rv, fs, fe, bz, ov, rd}, 0);
        rst = 1'b0;
        tick(12);
        chk("no_start_after_reset", 32'(fs_cnt[0] + fs_cnt[1]), 0);

        bus_start(); send_byte(8'hA5, 1'b1); bus_stop();
        chk("a5_lsb_first", 32'(last_rx[0]), 32'hA5);
        chk("a5_msb_first", 32'(last_rx[1]), 32'hA5);
        chk("a5_one_start", fs_cnt[0], 1);
        chk("a5_one_end", fe_cnt[0], 1);

        bus_start(); send_byte(8'h3C, 1'b1); send_byte(8'hC3, 1'b1); bus_stop();
        chk("c3_msb_first", 32'(last_rx[1]), 32'hC3);

        bus_start(); send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); bus_stop();
        chk("held_data", 32'(rd[0]), 32'h11);
        chk("held_valid", 32'(rv[0]), 1);
        chk("overrun_set", 32'(ov[0]), 1);
        drain();

        bus_start(); partial(4); bus_start(); send_byte(8'h7E, 1'b1); bus_stop();
        chk("7e_after_restart", 32'(last_rx[0]), 32'h7E);

        bus_start(); partial(5); bus_stop();

        repeat (12) begin
            bus_start();
            repeat ($urandom_range(1, 3)) send_byte(8'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                partial($urandom_range(1, 7));
                if ($urandom_range(0, 1) == 1) begin bus_start(); send_byte(8'($urandom), 1'b1); end
            end
            bus_stop();
        end
        drain();

        bus_start();
        set_ready(1'b1);
        data_bits(8'h5A);
        decide(8'h5A, ack);
        tick(Q); sda = 1'b1; tick(Q); scl = 1'b1; tick(Q);
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        chk("oe_after_mid_reset", 32'(oe), 0);
        chk("outputs_after_mid_reset", {oe, rv, fs, fe, bz, ov, rd}, 0);
        qa.delete(); qb.delete();
        pend = 1'b0; ov_exp = 1'b0; n_start = 0; n_stop = 0;
        for (int k = 0; k < 2; k++) begin fs_cnt[k] = 0; fe_cnt[k] = 0; end
        tick(1);
        rst = 1'b0;
        tick(20);
        chk("no_start_after_mid_reset", 32'(fs_cnt[0] + fs_cnt[1]), 0);
        chk("no_end_after_mid_reset", 32'(fe_cnt[0] + fe_cnt[1]), 0);
        chk("idle_after_mid_reset", 32'(bz), 0);

        bus_start(); send_byte(8'h96, 1'b1); bus_stop();
        chk("96_after_reset", 32'(last_rx[0]), 32'h96);
        chk("96_rev_after_reset", 32'(last_rx[1]), 32'h69);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
